// File: rtl/led_sequencer.sv
// Drives the 8-LED bank with one of four stepped patterns; a debounced button
// cycles the pattern and a pause input freezes the step prescaler.
module led_sequencer #(
  parameter int unsigned CLK_DIV    = 25_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iBTN_MODE,
  input  logic       iPAUSE,
  output logic [7:0] oLED,
  output logic [1:0] oMODE,
  output logic       oTICK
);

  localparam int unsigned PresW = $clog2(CLK_DIV);
  localparam int unsigned DebW  = $clog2(DEB_CYCLES);
  localparam logic [PresW-1:0] PresLast = PresW'(CLK_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ModeRun    = 2'd0,
    ModeBounce = 2'd1,
    ModeBlink  = 2'd2,
    ModeCount  = 2'd3
  } modeT;

  logic            sync1Q, sync2Q;
  logic            debLevelQ, debLevelD;
  logic [DebW-1:0] debCntQ, debCntD;
  logic [PresW-1:0] presQ, presD;
  logic            dirRightQ, dirRightD;
  modeT            modeQ, modeD;
  logic [7:0]      ledQ, ledD;
  logic            tickQ, tickD;
  logic            advance;
  logic [7:0]      stepLed;
  logic            stepDirRight;

  function automatic logic [7:0] initLed(input modeT m);
    unique case (m)
      ModeBlink: initLed = 8'hFF;
      ModeCount: initLed = 8'h00;
      default:   initLed = 8'h01;
    endcase
  endfunction

  // A level change is accepted only once s2 has disagreed for DEB_CYCLES edges.
  always_comb begin
    debLevelD = debLevelQ;
    debCntD   = '0;
    advance   = 1'b0;
    if (sync2Q != debLevelQ) begin
      if (debCntQ == DebLast) begin
        debLevelD = sync2Q;
        advance   = sync2Q;
      end else begin
        debCntD = debCntQ + DebW'(1);
      end
    end
  end

  always_comb begin
    stepLed      = ledQ;
    stepDirRight = dirRightQ;
    unique case (modeQ)
      ModeRun: stepLed = {ledQ[6:0], ledQ[7]};
      ModeBounce: begin
        if (!dirRightQ) begin
          if (ledQ == 8'h80) begin
            stepLed      = 8'h40;
            stepDirRight = 1'b1;
          end else begin
            stepLed = ledQ << 1;
          end
        end else if (ledQ == 8'h01) begin
          stepLed      = 8'h02;
          stepDirRight = 1'b0;
        end else begin
          stepLed = ledQ >> 1;
        end
      end
      ModeBlink: stepLed = ~ledQ;
      ModeCount: stepLed = ledQ + 8'd1;
    endcase
  end

  // Mode advance outranks a coinciding terminal count and swallows that step.
  always_comb begin
    modeD     = modeQ;
    ledD      = ledQ;
    presD     = presQ;
    dirRightD = dirRightQ;
    tickD     = 1'b0;
    if (advance) begin
      modeD     = modeT'(modeQ + 2'd1);
      ledD      = initLed(modeD);
      presD     = '0;
      dirRightD = 1'b0;
    end else if (!iPAUSE) begin
      if (presQ == PresLast) begin
        presD     = '0;
        ledD      = stepLed;
        dirRightD = stepDirRight;
        tickD     = 1'b1;
      end else begin
        presD = presQ + PresW'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1Q    <= 1'b0;
      sync2Q    <= 1'b0;
      debLevelQ <= 1'b0;
      debCntQ   <= '0;
      presQ     <= '0;
      dirRightQ <= 1'b0;
      modeQ     <= ModeRun;
      ledQ      <= 8'h01;
      tickQ     <= 1'b0;
    end else begin
      sync1Q    <= iBTN_MODE;
      sync2Q    <= sync1Q;
      debLevelQ <= debLevelD;
      debCntQ   <= debCntD;
      presQ     <= presD;
      dirRightQ <= dirRightD;
      modeQ     <= modeD;
      ledQ      <= ledD;
      tickQ     <= tickD;
    end
  end

  assign oLED  = ledQ;
  assign oMODE = modeQ;
  assign oTICK = tickQ;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboarded bench: a step-index reference model predicts every change of
// the {oLED, oMODE, oTICK} triple; a monitor pops and compares on each change.
module tb_led_sequencer;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned DebCycles = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] oLED;
  logic [1:0] oMODE;
  logic       oTICK;

  led_sequencer #(
    .CLK_DIV   (ClkDiv),
    .DEB_CYCLES(DebCycles)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iBTN_MODE(btn),
    .iPAUSE   (pause),
    .oLED     (oLED),
    .oMODE    (oMODE),
    .oTICK    (oTICK)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;
    int         cyc;
  } evT;

  evT q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: pattern is a pure function of mode and steps taken in it.
  int   mMode, mK, mCnt, mRun;
  bit   mDeb, mS1, mS2, mTick;
  logic [10:0] mPrev = 'x;

  function automatic logic [7:0] ledOf(input int mode, input int k);
    int p;
    case (mode)
      0: ledOf = 8'(1 << (k % 8));
      1: begin
        p = k % 14;
        ledOf = (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
      2: ledOf = (k % 2 == 0) ? 8'hFF : 8'h00;
      default: ledOf = 8'(k % 256);
    endcase
  endfunction

  task automatic modelEdge(input bit r, input bit b, input bit p);
    bit s2, adv;
    logic [10:0] cur;
    evT e;
    if (r) begin
      mMode = 0; mK = 0; mCnt = 0; mRun = 0;
      mDeb = 0; mS1 = 0; mS2 = 0; mTick = 0;
    end else begin
      s2  = mS2;
      mS2 = mS1;
      mS1 = b;
      adv = 0;
      if (s2 != mDeb) begin
        mRun++;
        if (mRun == DebCycles) begin
          mDeb = s2;
          mRun = 0;
          adv  = s2;
        end
      end else begin
        mRun = 0;
      end
      mTick = 0;
      if (adv) begin
        mMode = (mMode + 1) % 4;
        mK    = 0;
        mCnt  = 0;
      end else if (!p) begin
        mCnt++;
        if (mCnt == ClkDiv) begin
          mCnt  = 0;
          mK++;
          mTick = 1;
        end
      end
    end
    cur = {ledOf(mMode, mK), 2'(mMode), mTick};
    if (cur !== mPrev) begin
      e.led  = cur[10:3];
      e.mode = cur[2:1];
      e.tick = cur[0];
      e.cyc  = cyc + 1;
      q.push_back(e);
      mPrev = cur;
    end
  endtask

  task automatic applyCycle(input bit r, input bit b, input bit p);
    rst   = r;
    btn   = b;
    pause = p;
    modelEdge(r, b, p);
    @(negedge clk);
  endtask

  // Monitor: every change of the output triple is a presented result.
  initial begin
    logic [10:0] prevOut;
    logic [10:0] curOut;
    evT e;
    prevOut = 'x;
    forever begin
      @(posedge clk);
      #1;
      curOut = {oLED, oMODE, oTICK};
      if (curOut !== prevOut) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d got led=%h mode=%0d tick=%b, none expected",
                   cyc, oLED, oMODE, oTICK);
        end else begin
          e = q.pop_front();
          if (oLED !== e.led || oMODE !== e.mode || oTICK !== e.tick || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL output_event got cyc=%0d led=%h mode=%0d tick=%b want cyc=%0d led=%h mode=%0d tick=%b",
                     cyc, oLED, oMODE, oTICK, e.cyc, e.led, e.mode, e.tick);
          end
        end
        prevOut = curOut;
      end
    end
  end

  initial begin
    bit bLvl, pLvl;
    int bLeft, pLeft;
    repeat (3) applyCycle(1, 0, 0);
    repeat (40) applyCycle(0, 0, 0);
    // Short press is rejected, long press enters BOUNCE.
    repeat (3) applyCycle(0, 1, 0);
    repeat (10) applyCycle(0, 0, 0);
    repeat (10) applyCycle(0, 1, 0);
    repeat (10) applyCycle(0, 0, 0);
    repeat (64) applyCycle(0, 0, 0);
    repeat (10) applyCycle(0, 1, 0);
    repeat (30) applyCycle(0, 0, 0);
    repeat (10) applyCycle(0, 1, 0);
    // Long enough in COUNT to wrap 0xFF -> 0x00.
    repeat (1100) applyCycle(0, 0, 0);
    repeat (2) applyCycle(0, 0, 0);
    repeat (10) applyCycle(0, 0, 1);
    repeat (10) applyCycle(0, 0, 0);
    repeat (10) applyCycle(0, 1, 0);
    repeat (10) applyCycle(0, 0, 0);
    bLvl = 0; pLvl = 0; bLeft = 0; pLeft = 0;
    for (int i = 0; i < 4000; i++) begin
      if (bLeft == 0) begin
        bLvl  = ~bLvl;
        bLeft = $urandom_range(1, 12);
      end
      if (pLeft == 0) begin
        pLvl  = ($urandom_range(0, 3) == 0);
        pLeft = $urandom_range(1, 20);
      end
      bLeft--;
      pLeft--;
      applyCycle($urandom_range(0, 399) == 0, bLvl, pLvl);
    end
    repeat (4) applyCycle(0, 0, 0);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events got %0d outstanding want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
